// File: rtl/audio_nios_i2c_pkg.sv
// Shared types and constants for the audio codec I2C master.
// Each bus stage is a run of 4-phase units; the helpers below decode what the lines do per phase.
package audio_nios_i2c_pkg;

  localparam int unsigned DivWidth = 16;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StByte,
    StAck,
    StStop
  } state_e;

  typedef logic [1:0] phase_t;

  localparam logic [1:0] RegData = 2'd0;
  localparam logic [1:0] RegCmd  = 2'd1;
  localparam logic [1:0] RegDiv  = 2'd2;

  localparam int unsigned CmdStart = 0;
  localparam int unsigned CmdStop  = 1;
  localparam int unsigned CmdWrite = 2;
  localparam int unsigned CmdRead  = 3;
  localparam int unsigned CmdMack  = 4;

  // Returns {scl_oe, sda_oe} for a phase; drive is the SDA pull held through a bit/ack unit.
  function automatic logic [1:0] phase_lines(state_e st, phase_t ph, logic drive);
    logic [1:0] lines;
    lines = 2'b00;
    unique case (st)
      StStart:       lines = {ph == 2'd3, ph >= 2'd2};
      StByte, StAck: lines = {(ph == 2'd0) || (ph == 2'd3), drive};
      StStop:        lines = {ph == 2'd0, ph != 2'd3};
      default:       lines = 2'b00;
    endcase
    return lines;
  endfunction

  // Phases where SCL is released and a slave may stretch the clock.
  function automatic logic scl_released(state_e st, phase_t ph);
    logic rel;
    rel = 1'b0;
    unique case (st)
      StStart:       rel = (ph == 2'd1);
      StByte, StAck: rel = (ph == 2'd1) || (ph == 2'd2);
      StStop:        rel = (ph == 2'd2);
      default:       rel = 1'b0;
    endcase
    return rel;
  endfunction

endpackage

// File: rtl/audio_nios_i2c_tick.sv
// Phase divider: counts 0..div and ticks on div, so a phase lasts div+1 cycles.
// Freezes while the slave stretches SCL; restart reloads the count for a new command.
module audio_nios_i2c_tick
  import audio_nios_i2c_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                restart,
  input  logic                freeze,
  input  logic [DivWidth-1:0] div,
  output logic                tick
);

  logic [DivWidth-1:0] cnt_q;

  assign tick = !restart && !freeze && (cnt_q >= div);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (restart) begin
      cnt_q <= '0;
    end else if (!freeze) begin
      cnt_q <= tick ? '0 : cnt_q + DivWidth'(1);
    end
  end

endmodule

// File: rtl/audio_nios_i2c_master.sv
// Avalon-MM byte-level I2C master driving the audio codec configuration bus.
// Software issues START/WRITE/READ/STOP through CMD and polls busy; both lines are open-drain.
module audio_nios_i2c_master
  import audio_nios_i2c_pkg::*;
#(
  parameter logic [DivWidth-1:0] DEFAULT_DIV = DivWidth'(124)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        scl_oe,
  output logic        sda_oe,
  input  logic        scl_in,
  input  logic        sda_in
);

  state_e              state_q;
  phase_t              phase_q;
  logic [2:0]          bit_q;
  logic [7:0]          tx_q, rx_q;
  logic [DivWidth-1:0] div_q;
  logic                ack_err_q, cmd_err_q;
  logic                wr_q, rd_q, stop_q, mack_q;

  logic       busy, wr_en, cmd_wr, cmd_conflict, accept, tick, freeze;
  logic [4:0] cmd;
  state_e     first_st, next_st;
  logic       first_drive, next_drive;
  logic [2:0] next_bit;
  logic       unused_wdata;

  assign cmd          = writedata[4:0];
  assign unused_wdata = ^writedata[31:16];

  always_comb begin
    busy         = (state_q != StIdle);
    wr_en        = chipselect && !write_n && !busy;
    cmd_wr       = wr_en && (address == RegCmd);
    cmd_conflict = cmd[CmdWrite] && cmd[CmdRead];
    accept       = cmd_wr && !cmd_conflict && (|cmd[3:0]);
    freeze       = scl_released(state_q, phase_q) && !scl_in;
  end

  // First stage of a freshly accepted command.
  always_comb begin
    if (cmd[CmdStart]) begin
      first_st = StStart;
    end else if (cmd[CmdWrite] || cmd[CmdRead]) begin
      first_st = StByte;
    end else begin
      first_st = StStop;
    end
    first_drive = (first_st == StByte) && cmd[CmdWrite] && !tx_q[7];
  end

  // Stage following the current one once its last unit completes.
  always_comb begin
    next_st = StIdle;
    unique case (state_q)
      StStart: next_st = (wr_q || rd_q) ? StByte : (stop_q ? StStop : StIdle);
      StByte:  next_st = (bit_q == 3'd0) ? StAck : StByte;
      StAck:   next_st = stop_q ? StStop : StIdle;
      default: next_st = StIdle;
    endcase
    next_bit = (state_q == StByte) ? bit_q - 3'd1 : 3'd7;
    if (next_st == StByte) begin
      next_drive = wr_q && !tx_q[next_bit];
    end else if (next_st == StAck) begin
      next_drive = rd_q && mack_q;
    end else begin
      next_drive = 1'b0;
    end
  end

  audio_nios_i2c_tick u_tick (
    .clk     (clk),
    .reset   (reset),
    .restart (accept),
    .freeze  (freeze),
    .div     (div_q),
    .tick    (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      phase_q   <= 2'd0;
      bit_q     <= 3'd7;
      tx_q      <= 8'h00;
      rx_q      <= 8'h00;
      div_q     <= DEFAULT_DIV;
      ack_err_q <= 1'b0;
      cmd_err_q <= 1'b0;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      stop_q    <= 1'b0;
      mack_q    <= 1'b0;
      scl_oe    <= 1'b0;
      sda_oe    <= 1'b0;
    end else begin
      if (wr_en && (address == RegData)) begin
        tx_q <= writedata[7:0];
      end
      if (wr_en && (address == RegDiv)) begin
        div_q <= (writedata[DivWidth-1:0] == '0) ? DivWidth'(1) : writedata[DivWidth-1:0];
      end
      if (cmd_wr && cmd_conflict) begin
        cmd_err_q <= 1'b1;
      end

      if (accept) begin
        cmd_err_q          <= 1'b0;
        ack_err_q          <= 1'b0;
        state_q            <= first_st;
        phase_q            <= 2'd0;
        bit_q              <= 3'd7;
        wr_q               <= cmd[CmdWrite];
        rd_q               <= cmd[CmdRead];
        stop_q             <= cmd[CmdStop];
        mack_q             <= cmd[CmdMack];
        {scl_oe, sda_oe}   <= phase_lines(first_st, 2'd0, first_drive);
      end else if (busy && tick) begin
        // Last cycle of p2 is the SCL-high sample point.
        if (phase_q == 2'd2) begin
          if ((state_q == StByte) && rd_q) begin
            rx_q <= {rx_q[6:0], sda_in};
          end
          if ((state_q == StAck) && wr_q && sda_in) begin
            ack_err_q <= 1'b1;
          end
        end
        if (phase_q != 2'd3) begin
          phase_q          <= phase_q + 2'd1;
          {scl_oe, sda_oe} <= phase_lines(state_q, phase_q + 2'd1, sda_oe);
        end else begin
          state_q <= next_st;
          phase_q <= 2'd0;
          bit_q   <= next_bit;
          // Going idle keeps the p3 levels, so a command without STOP holds SCL low.
          if (next_st != StIdle) begin
            {scl_oe, sda_oe} <= phase_lines(next_st, 2'd0, next_drive);
          end
        end
      end
    end
  end

  always_comb begin
    readdata = 32'h0;
    case (address)
      RegData: readdata = {24'h0, rx_q};
      RegCmd:  readdata = {29'h0, cmd_err_q, ack_err_q, busy};
      RegDiv:  readdata = {{(32 - DivWidth){1'b0}}, div_q};
      default: readdata = 32'h0;
    endcase
  end

endmodule

// File: doc/audio_nios_i2c_master.md
# audio_nios_i2c_master

Avalon-MM byte-level I2C master for the audio subsystem: it generates SCL/SDA toward the audio codec configuration bus and replaces Nios bit-banging of single-bit SCL/SDA output ports. Software issues START / WRITE / READ / STOP commands through three registers and polls a busy flag. Both bus lines are open-drain: the block only ever pulls a line low or releases it. SCL clock stretching by the slave is honoured.

## Interface
- DEFAULT_DIV, 124: reset value of the quarter-bit divider. At 50 MHz this gives 100 kHz SCL (4 × 125 cycles per bit).
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- address  in  2  register select
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- readdata  out  32  combinational read data, selected by address
- scl_oe  out  1  1 = pull SCL low
- sda_oe  out  1  1 = pull SDA low
- scl_in  in  1  sampled SCL pin, already synchronised at top level
- sda_in  in  1  sampled SDA pin, already synchronised

## Operation
- Write decode: a write occurs when chipselect && !write_n.
- Register map:
  - addr 0 DATA. Write sets tx[7:0]. Read returns {24'b0, rx[7:0]}.
  - addr 1 CMD / STATUS. Write bits: 0 START, 1 STOP, 2 WRITE, 3 READ, 4 MACK. MACK = 1 makes the master ACK a READ; otherwise it sends NACK. Read returns {29'b0, cmd_err, ack_err, busy}.
  - addr 2 DIV. Write sets div[15:0]; a value of 0 is stored as 1. Read returns {16'b0, div}.
  - addr 3 reads as 0.
- Write gating: writes to CMD, DATA or DIV while busy = 1 are ignored.
- CMD with both WRITE and READ set: nothing executes, cmd_err ← 1. cmd_err is cleared by the next valid CMD write.
- CMD with no bits set: ignored.
- Execution order within one command: START, then WRITE or READ, then STOP. Any subset of these is allowed.
- ack_err: cleared when a command is accepted; set if the slave NACKs a WRITE.
- State machine: IDLE → START → BYTE → ACK → STOP → IDLE. Stages not requested by the command are skipped. Each stage is made of 4-phase units.
  - START (1 unit):
    - p0: release SDA and SCL.
    - p1: wait for scl_in = 1.
    - p2: SDA low.
    - p3: SCL low.
    - Valid as a repeated START.
  - BYTE (8 units, MSB first):
    - p0: SCL low, drive SDA (WRITE: tx bit; READ: release).
    - p1: release SCL.
    - p2: SCL high; sample sda_in into rx on the last cycle of p2.
    - p3: SCL low.
  - ACK (1 unit):
    - WRITE: SDA released; sda_in = 1 at sample time sets ack_err.
    - READ: SDA driven low when MACK = 1, released otherwise.
  - STOP (1 unit):
    - p0: SCL low, SDA low.
    - p1: release SCL.
    - p2: wait for scl_in = 1.
    - p3: release SDA.
- After a command without STOP, SCL stays low (bus held).

## Timing
- Phase tick: the divider counter counts 0..div and emits a tick on reaching div, so one phase lasts div+1 cycles. The counter reloads to 0 when a command is accepted.
- Clock stretching: in any phase where SCL is released (START p1, BYTE/ACK p1–p2, STOP p2), the counter freezes while scl_in = 0. It does not advance until scl_in = 1.
- busy rises on the clock edge that accepts the CMD write; readable as 1 from the next cycle. busy falls on the edge of the final p3 tick.
- Unstretched command durations, with P = div+1:
  - START: 4P
  - WRITE or READ: 36P
  - STOP: 4P
- scl_oe and sda_oe are registered and change only on phase boundaries.
- Reset values: scl_oe = 0, sda_oe = 0, busy = 0, ack_err = 0, cmd_err = 0, tx = 0, rx = 0, div = DEFAULT_DIV, state = IDLE.
- Reset mid-transaction: both lines are released at the next edge, with no STOP generated.
- rx holds a stable value from the end of READ until the next READ begins.

## Structure
- Package audio_nios_i2c_pkg holds:
  - state enum: IDLE, START, BYTE, ACK, STOP
  - 2-bit phase type
  - register offsets
  - CMD bit positions
  - DIV width (16)
- Sub-module audio_nios_i2c_tick: phase divider with stretch-freeze input, a restart input, and tick output.

## Test plan
- Reset: assert reset for 3 cycles → scl_oe = sda_oe = 0; STATUS reads 0; DIV reads 124.
- Write byte with ACK: set DIV = 3, DATA = 0x34, CMD = START|WRITE|STOP; slave model ACKs → SDA shows 0,0,1,1,0,1,0,0 on the SCL rising edges; busy is high for exactly 44×4 cycles; ack_err = 0; both lines end released.
- Write byte with NACK: same command with sda_in held high throughout → ack_err = 1 once busy = 0.
- Read byte: slave drives 0xA5; CMD = READ|STOP with MACK = 0 → DATA reads 0xA5; sda_oe = 0 during the ACK bit.
- Clock stretch and write gating:
  - hold scl_in low for 50 cycles in bit 3 p1 → total command length grows by exactly 50 cycles;
  - a DATA write during busy leaves tx unchanged.
- Error cases:
  - CMD = WRITE|READ → cmd_err = 1, busy stays 0;
  - reset asserted mid-BYTE → lines released on the next edge, busy = 0.
